// File: rtl/sd_cmd_tx_pkg.sv
// sd_pkg: shared definitions for the SPI-mode SD command path.
//   tx_state_t  - command transmitter state encoding
//   FRAME_BITS  - bits in one command frame (start .. end bit)
//   CRC7_POLY   - x^7+x^3+1 with the x^7 term implied
//   CMDx        - command indices used by the controller
//   crc7_step   - one serial CRC7 update
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_FRAME  = 3'd2,
        ST_POST   = 3'd3,
        ST_FINISH = 3'd4
    } tx_state_t;

    localparam int         FRAME_BITS = 48;
    localparam logic [6:0] CRC7_POLY  = 7'h09;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD58  = 6'd58;
    localparam logic [5:0] ACMD41 = 6'd41;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// sd_cmd_tx_if: controller <-> command transmitter bundle.
//   start/cmd/arg          - send request from the controller
//   DI                     - serial line towards the card
//   busy/isTXFinish/sentCmd - transmitter status back to the controller
// master = controller side, slave = transmitter side.
interface sd_cmd_tx_if;
    logic        start;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        DI;
    logic        busy;
    logic        isTXFinish;
    logic [5:0]  sentCmd;

    modport master (output start, cmd, arg,
                    input  DI, busy, isTXFinish, sentCmd);
    modport slave  (input  start, cmd, arg,
                    output DI, busy, isTXFinish, sentCmd);
endinterface

// File: rtl/sd_cmd_tx_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB-first.
//   clk, reset  - clock, synchronous active-high reset
//   clr         - synchronous clear, wins over en
//   en, bit_in  - fold bit_in into the CRC this cycle
//   crc         - current remainder
// Feeding bit_in = crc[6] zeroes the feedback, so the same enable shifts
// the remainder out MSB first once the payload is done.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            crc <= 7'h00;
        else if (en)
            crc <= crc7_step(crc, bit_in);
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: SPI-mode SD command transmitter.
// Serialises {0, 1, cmd[5:0], arg[31:0], crc7[6:0], 1} MSB first on DI,
// framed by PRE_ONES idle ones before and POST_ONES idle ones after.
//   clk, reset - clock, synchronous active-high reset
//   bus.start  - send request, only honoured in IDLE
//   bus.cmd/arg - latched on an accepted start
//   bus.DI     - registered serial output, idles high
//   bus.busy   - cycle after accept through the finish cycle
//   bus.isTXFinish - one-cycle pulse on the finish cycle
//   bus.sentCmd - command index of the current/last frame
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int PRE_ONES  = 8,
    parameter int POST_ONES = 8
) (
    input  logic           clk,
    input  logic           reset,
    sd_cmd_tx_if.slave     bus
);

    // The shared 6-bit bit counter cannot represent longer pads.
    if (PRE_ONES < 0 || PRE_ONES > 63 || POST_ONES < 0 || POST_ONES > 63) begin : g_bad_param
        $error("sd_cmd_tx: PRE_ONES/POST_ONES must be in 0..63");
    end

    localparam logic [5:0] PRE_LAST  = (PRE_ONES  == 0) ? 6'd0 : 6'(PRE_ONES - 1);
    localparam logic [5:0] POST_LAST = (POST_ONES == 0) ? 6'd0 : 6'(POST_ONES - 1);
    localparam logic [5:0] FRAME_TOP = 6'(FRAME_BITS - 1);

    tx_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;     // PRE/POST: ones left - 1; FRAME: index of bit on DI
    logic [38:0] sh_q, sh_d;       // frame bits 46..8; the start bit is implicit
    logic        di_q, di_d;
    logic        busy_q, busy_d;
    logic        fin_q, fin_d;
    logic [5:0]  sent_q, sent_d;
    logic        go_frame;

    logic        crc_clr, crc_en, crc_bit;
    logic [6:0]  crc;

    sd_crc7 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        di_d     = 1'b1;
        busy_d   = busy_q;
        fin_d    = 1'b0;
        sent_d   = sent_q;
        go_frame = 1'b0;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_bit  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    sh_d    = {1'b1, bus.cmd, bus.arg};
                    sent_d  = bus.cmd;
                    crc_clr = 1'b1;
                    busy_d  = 1'b1;
                    if (PRE_ONES == 0) begin
                        go_frame = 1'b1;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LAST;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == 6'd0) go_frame = 1'b1;
                else               cnt_d    = cnt_q - 6'd1;
            end
            ST_FRAME: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q >= 6'd9) begin
                    // next bit is payload 46..8
                    di_d    = sh_q[38];
                    sh_d    = {sh_q[37:0], 1'b0};
                    crc_en  = 1'b1;
                    crc_bit = sh_q[38];
                end else if (cnt_q >= 6'd2) begin
                    // next bit is CRC 7..1; crc already covers bit 8
                    di_d    = crc[6];
                    crc_en  = 1'b1;
                    crc_bit = crc[6];
                end else if (cnt_q == 6'd0) begin
                    if (POST_ONES == 0) begin
                        state_d = ST_FINISH;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = ST_POST;
                        cnt_d   = POST_LAST;
                    end
                end
                // cnt_q == 1: next bit is the end bit, di_d default 1
            end
            ST_POST: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_FINISH;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Start bit is always 0 and leaves a cleared CRC at 0, so entering
        // straight from IDLE with crc_clr also set gives the same remainder.
        if (go_frame) begin
            state_d = ST_FRAME;
            cnt_d   = FRAME_TOP;
            di_d    = 1'b0;
            crc_en  = 1'b1;
            crc_bit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            sh_q    <= '0;
            di_q    <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            sent_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            di_q    <= di_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            sent_q  <= sent_d;
        end
    end

    assign bus.DI         = di_q;
    assign bus.busy       = busy_q;
    assign bus.isTXFinish = fin_q;
    assign bus.sentCmd    = sent_q;

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
SPI-mode SD command transmitter, the send-side counterpart of the SD response receiver. It serialises one 48-bit command frame onto the card DI line, MSB first, one bit per clk:
- frame = start bit, transmit bit, cmd index, 32-bit argument, CRC7, end bit
- CRC7 is generated on the fly
- leading and trailing idle '1' padding is optional

It sits between the SD controller FSM and the SPI pin logic. Its latched cmd output feeds the receiver's cmd input.

Parameters:
PRE_ONES, 8, number of idle '1' bits driven before the frame; 0 is legal.
POST_ONES, 8, number of idle '1' bits driven after the end bit (Ncr gap); 0 is legal.

Ports:
clk  input  1  system clock; one DI bit per rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to send; sampled only in IDLE
cmd  input  6  command index; latched on accepted start
arg  input  32  command argument; latched on accepted start
DI  output  1  serial data to card; idles high
busy  output  1  high from the cycle after an accepted start until the finish cycle, inclusive
isTXFinish  output  1  one-cycle pulse, registered, when the last POST bit has been driven
sentCmd  output  6  latched cmd of the current/last command; holds until the next accepted start

Behaviour:
- Reset values: DI=1, busy=0, isTXFinish=0, sentCmd=0, state=IDLE, CRC register=0.
- Reset mid-operation: the current frame is abandoned with no finish pulse, and DI=1 on the next cycle.
- Frame bit order (bit 47 first):
  - 47 = 0 (start)
  - 46 = 1 (transmit)
  - 45:40 = cmd
  - 39:8 = arg
  - 7:1 = CRC7
  - 0 = 1 (end)
- CRC7:
  - polynomial x^7+x^3+1, register starts at 0
  - updated serially over bits 47..8 as they are driven: fb = crc[6]^bit; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00)
  - bits 7:1 are then shifted out from crc[6] downward
- States:
  - IDLE: DI=1. On start=1 (cycle N), latch cmd/arg into the shift register and sentCmd, clear the CRC, and go to PRE. If PRE_ONES=0, go straight to FRAME.
  - PRE: DI=1 for PRE_ONES cycles starting at N+1.
  - FRAME: 48 cycles; DI = current frame bit, with bit 47 at the first FRAME cycle.
  - POST: DI=1 for POST_ONES cycles.
  - FINISH: one cycle; isTXFinish=1, busy=1, DI=1. Then IDLE.
- Latency: first frame bit appears PRE_ONES+1 cycles after the start cycle. The FINISH cycle is N+1+PRE_ONES+48+POST_ONES.
- start while busy, or during FINISH: ignored, no queuing. start may be held high; a new frame begins only on the IDLE cycle after FINISH.
- cmd/arg changes after acceptance do not affect the frame in flight.
- Bit counter: 6-bit down-counter reused across PRE/FRAME/POST. Parameters above 63 are rejected at elaboration.
- DI is registered, so no combinational path from inputs to DI.

Decomposition:
- Shared package sd_pkg:
  - state encoding constants (IDLE/PRE/FRAME/POST/FINISH)
  - FRAME_BITS=48
  - CRC7_POLY=7'h09
  - command index constants CMD0=0, CMD8=8, CMD17=17, CMD55=55, CMD58=58, ACMD41=41
- One natural sub-module: sd_crc7 (serial CRC7 with clear, enable and data-bit inputs and a 7-bit crc output). It is reusable for a data-path CRC checker.

Test Plan:
- Reset, then start with cmd=0, arg=0, PRE_ONES=8, POST_ONES=8 -> DI carries 8 ones, then bytes 0x40 00 00 00 00 95, then 8 ones; isTXFinish pulses at N+65; sentCmd=0.
- cmd=8, arg=32'h000001AA -> frame bytes 0x48 00 00 01 AA 87.
- cmd=55, arg=0 -> frame bytes 0x77 00 00 00 00 65; busy high exactly 65 cycles.
- start pulsed again at frame bit 20 with cmd=17 -> ignored; frame and sentCmd=55 unchanged; no extra isTXFinish.
- reset asserted at frame bit 30 -> DI=1, busy=0 next cycle, no finish pulse; a following start with cmd=0 sends a correct 0x40..0x95 frame.
- PRE_ONES=0, POST_ONES=0, start held high -> start bit at N+1; back-to-back frames separated only by FINISH and IDLE cycles (2 cycles of DI=1).
